// File: rtl/mastermind_scoreboard_if.sv
// Bundle of the result/control inputs and status/history outputs of the
// Mastermind scoreboard; master is the game controller, slave is the scoreboard.
interface mastermind_scoreboard_if;
    logic       result_valid;
    logic [2:0] red;
    logic [2:0] white;
    logic       new_game;
    logic [2:0] hist_idx;
    logic [1:0] game_state;
    logic       accept_guess;
    logic [3:0] guess_count;
    logic [2:0] last_red;
    logic [2:0] last_white;
    logic [2:0] hist_red;
    logic [2:0] hist_white;
    logic       hist_valid;
    logic       error;

    modport master (
        output result_valid, red, white, new_game, hist_idx,
        input  game_state, accept_guess, guess_count, last_red, last_white,
               hist_red, hist_white, hist_valid, error
    );

    modport slave (
        input  result_valid, red, white, new_game, hist_idx,
        output game_state, accept_guess, guess_count, last_red, last_white,
               hist_red, hist_white, hist_valid, error
    );
endinterface

// File: rtl/mastermind_scoreboard.sv
// Mastermind game scoreboard: counts scored guesses, decides WIN/LOSE and
// flags malformed results. Define MASTERMIND_HISTORY_EN for per-guess history.
module mastermind_scoreboard #(
    parameter int MAX_GUESSES = 8
) (
    input logic                     clk,
    input logic                     resetn,
    mastermind_scoreboard_if.slave  bus
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } state_e;

    state_e     state, state_nxt;
    logic [3:0] guess_count;
    logic [2:0] last_red, last_white;
    logic       error_q;

    logic [3:0] rw_sum;
    logic       well_formed;
    logic       in_play;
    logic       accept;
    logic       malformed;
    logic       last_guess;

    // A perfect score leaves no pegs for white, so (4,w>0) is malformed too.
    assign rw_sum      = {1'b0, bus.red} + {1'b0, bus.white};
    assign well_formed = (bus.red <= 3'd4) && (bus.white <= 3'd4) && (rw_sum <= 4'd4)
                         && !((bus.red == 3'd4) && (bus.white != 3'd0));
    assign in_play     = (state == PLAY);
    assign accept      = in_play && bus.result_valid && !bus.new_game && well_formed;
    assign malformed   = in_play && bus.result_valid && !bus.new_game && !well_formed;
    assign last_guess  = ((guess_count + 4'd1) == 4'(MAX_GUESSES));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) state <= PLAY;
        else         state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        if (bus.new_game) begin
            state_nxt = PLAY;
        end else if (accept) begin
            if (bus.red == 3'd4)  state_nxt = WIN;
            else if (last_guess)  state_nxt = LOSE;
        end
    end

    always_comb begin
        bus.game_state   = state;
        bus.accept_guess = (state == PLAY);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            guess_count <= 4'd0;
            last_red    <= 3'd0;
            last_white  <= 3'd0;
            error_q     <= 1'b0;
        end else if (bus.new_game) begin
            guess_count <= 4'd0;
            last_red    <= 3'd0;
            last_white  <= 3'd0;
            error_q     <= 1'b0;
        end else if (accept) begin
            guess_count <= guess_count + 4'd1;
            last_red    <= bus.red;
            last_white  <= bus.white;
        end else if (malformed) begin
            error_q     <= 1'b1;
        end
    end

    assign bus.guess_count = guess_count;
    assign bus.last_red    = last_red;
    assign bus.last_white  = last_white;
    assign bus.error       = error_q;

`ifdef MASTERMIND_HISTORY_EN
    logic [5:0] hist_mem [8];
    logic [5:0] hist_word;

    // NOTE: the history array is reset explicitly because stored entries must read back as zero after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) hist_mem[i] <= 6'd0;
        end else if (accept) begin
            hist_mem[guess_count[2:0]] <= {bus.red, bus.white};
        end
    end

    // Validity comes from guess_count, so new_game invalidates every entry at once.
    assign bus.hist_valid = ({1'b0, bus.hist_idx} < guess_count);
    assign hist_word      = hist_mem[bus.hist_idx];
    assign bus.hist_red   = bus.hist_valid ? hist_word[5:3] : 3'd0;
    assign bus.hist_white = bus.hist_valid ? hist_word[2:0] : 3'd0;
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^bus.hist_idx;
    assign bus.hist_valid  = 1'b0;
    assign bus.hist_red    = 3'd0;
    assign bus.hist_white  = 3'd0;
`endif

endmodule

// File: doc/mastermind_scoreboard.md
MASTERMIND_SCOREBOARD -- requirements
Module: mastermind_scoreboard

Interface
REQ-001 SHALL have parameter MAX_GUESSES, default 8, meaning the number of scored guesses before the game is lost (legal range 1..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port result_valid  input  1  one-cycle pulse marking red/white as a completed comparison result.
REQ-005 SHALL have port red  input  3  count of pegs with correct colour and position (0..4).
REQ-006 SHALL have port white  input  3  count of pegs with correct colour and wrong position (0..4).
REQ-007 SHALL have port new_game  input  1  one-cycle pulse that restarts the game.
REQ-008 SHALL have port hist_idx  input  3  history read index.
REQ-009 SHALL have port game_state  output  2  0=PLAY, 1=WIN, 2=LOSE; 3 is never driven.
REQ-010 SHALL have port accept_guess  output  1  high only in PLAY.
REQ-011 SHALL have port guess_count  output  4  number of accepted results in the current game.
REQ-012 SHALL have port last_red, last_white  output  3 each  most recently accepted result.
REQ-013 SHALL have port hist_red, hist_white  output  3 each  stored result at hist_idx.
REQ-014 SHALL have port hist_valid  output  1  high when hist_idx < guess_count.
REQ-015 SHALL have port error  output  1  sticky flag for a malformed result.

Function
REQ-016 SHALL implement the FSM states PLAY, WIN and LOSE; the only exit from WIN or LOSE is new_game or reset.
REQ-017 SHALL, in PLAY, accept a result when result_valid=1, red<=4, white<=4, red+white<=4 and not (red==4 and white!=0).
REQ-018 SHALL, on an accepted result, register last_red/last_white and increment guess_count, with all changes visible the cycle after the pulse (latency 1).
REQ-019 SHALL transition PLAY->WIN on an accepted result with red==4, including on the final guess (WIN takes priority over LOSE).
REQ-020 SHALL transition PLAY->LOSE on an accepted result with red<4 when the incremented guess_count equals MAX_GUESSES.
REQ-021 SHALL, on a malformed result in PLAY, set error, leave every other output unchanged and not count the guess.
REQ-022 SHALL ignore result_valid entirely in WIN and LOSE; error is not set and no count or history changes occur.
REQ-023 SHALL never let guess_count exceed MAX_GUESSES.
REQ-024 SHALL, on new_game in any state, on the next cycle enter PLAY, zero guess_count, last_red, last_white and error, and invalidate all history.
REQ-025 SHALL give new_game priority when it coincides with result_valid; the result is dropped.
REQ-026 SHALL treat hist_* outputs as combinational from hist_idx and storage; hist_red/hist_white read 0 when hist_valid=0.

Reset
REQ-027 SHALL on resetn=0 at a clk edge set game_state=PLAY, accept_guess=1, guess_count=0, last_red=0, last_white=0 and error=0, and clear all history entries to 0.
REQ-028 SHALL give reset priority over new_game and result_valid; reset during any state behaves identically.

Configuration
REQ-029 SHALL, when MASTERMIND_HISTORY_EN is defined, include an 8-entry x 6-bit history buffer; an accepted result writes entry guess_count (pre-increment value).
REQ-030 SHALL, when MASTERMIND_HISTORY_EN is undefined, omit the history storage and tie hist_red, hist_white and hist_valid to 0, with all other behaviour unchanged.

Verification
REQ-031 SHALL cover: results (1,2),(2,1),(4,0) in PLAY -> guess_count=3, game_state=WIN one cycle after the third pulse, last=(4,0).
REQ-032 SHALL cover: 8 results of (0,0) with MAX_GUESSES=8 -> game_state=LOSE after the 8th; a 9th pulse leaves guess_count=8 and error=0.
REQ-033 SHALL cover: 7x(1,1) then (4,0) -> WIN, not LOSE, with guess_count=8.
REQ-034 SHALL cover: result (3,2) -> error=1, guess_count unchanged; then new_game -> error=0, PLAY, guess_count=0.
REQ-035 SHALL cover: new_game coincident with result_valid (2,2) after two guesses -> guess_count=0 and last=(0,0).
REQ-036 SHALL cover, with MASTERMIND_HISTORY_EN: results (1,0),(0,3) then hist_idx=1 -> hist=(0,3), hist_valid=1; hist_idx=2 -> hist_valid=0 and hist=(0,0).
